segment_register_file_ctx: RTL and testbench

- Parametrised successor to the 4-entry segment register file: NUM_REGS x DATA_WIDTH live segment registers, NUM_RD_PORTS independent registered read ports with write bypass, and a dedicated CS output.
- Adds a shadow bank with a sequenced save/restore engine for interrupt/context-switch entry and exit.
- Adds a cs_changed pulse so the prefetch unit can flush on any CS update.
- Sits between microcode register-select logic and the address generator/prefetcher.

---
 rtl/segment_register_file_ctx.sv | 162 ++++++++++++++++
 tb/tb_segment_register_file_ctx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/segment_register_file_ctx.sv
// Segment register file with multi-port registered reads, write bypass,
// dedicated CS output and a shadow bank with sequenced save/restore.
module segment_register_file_ctx #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter logic [DATA_WIDTH-1:0] CS_RESET = DATA_WIDTH'(16'hFFFF),
  localparam int unsigned SEL_W = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_RD_PORTS*SEL_W-1:0]      rd_sel,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_val,
  input  logic                               wr_en,
  input  logic [SEL_W-1:0]                   wr_sel,
  input  logic [DATA_WIDTH-1:0]              wr_val,
  output logic [DATA_WIDTH-1:0]              cs,
  output logic                               cs_changed,
  input  logic                               save_req,
  input  logic                               restore_req,
  output logic                               busy,
  output logic                               done,
  output logic                               wr_err
);

  localparam logic [SEL_W-1:0] CS_IDX   = SEL_W'(1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [SEL_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] live   [NUM_REGS];
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];

  logic                  save_en_c;
  logic                  last_c;
  logic                  wr_act_c;
  logic [SEL_W-1:0]      wr_idx_c;
  logic [DATA_WIDTH-1:0] wr_data_c;

  // FSM state and copy index register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state: save has priority over restore; requests ignored while busy
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (save_req)         state_next = SAVE;
        else if (restore_req) state_next = RESTORE;
      end
      SAVE, RESTORE: begin
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + SEL_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output decode: merge external writes and restore copies onto one write port
  always_comb begin
    save_en_c = 1'b0;
    last_c    = 1'b0;
    wr_act_c  = 1'b0;
    wr_idx_c  = wr_sel;
    wr_data_c = wr_val;
    case (state)
      IDLE: begin
        wr_act_c = wr_en;
      end
      SAVE: begin
        save_en_c = 1'b1;
        last_c    = (idx == LAST_IDX);
      end
      RESTORE: begin
        wr_act_c  = 1'b1;
        wr_idx_c  = idx;
        wr_data_c = shadow[idx];
        last_c    = (idx == LAST_IDX);
      end
      default: begin
        wr_act_c = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign cs   = live[CS_IDX];

  // Live bank update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        live[i] <= (i == 1) ? CS_RESET : '0;
      end
    end else if (wr_act_c) begin
      live[wr_idx_c] <= wr_data_c;
    end
  end

  // Shadow bank update during save
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (save_en_c) begin
      shadow[idx] <= live[idx];
    end
  end

  // Registered read ports with same-edge write bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_val <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (wr_act_c && (wr_idx_c == rd_sel[p*SEL_W +: SEL_W])) begin
          rd_val[p*DATA_WIDTH +: DATA_WIDTH] <= wr_data_c;
        end else begin
          rd_val[p*DATA_WIDTH +: DATA_WIDTH] <= live[rd_sel[p*SEL_W +: SEL_W]];
        end
      end
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_changed <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      cs_changed <= wr_act_c && (wr_idx_c == CS_IDX);
      done       <= last_c;
      wr_err     <= wr_en && busy;
    end
  end

endmodule

// File: tb/tb_segment_register_file_ctx.sv
// Directed self-checking bench for segment_register_file_ctx.
module tb_segment_register_file_ctx;

  logic        clk;
  logic        reset;
  logic [3:0]  rd_sel;
  logic [31:0] rd_val;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_val;
  logic [15:0] cs;
  logic        cs_changed;
  logic        save_req;
  logic        restore_req;
  logic        busy;
  logic        done;
  logic        wr_err;

  int n_checks = 0;
  int n_errors = 0;

  segment_register_file_ctx dut (
    .clk        (clk),
    .reset      (reset),
    .rd_sel     (rd_sel),
    .rd_val     (rd_val),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_val     (wr_val),
    .cs         (cs),
    .cs_changed (cs_changed),
    .save_req   (save_req),
    .restore_req(restore_req),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [15:0] val);
    wr_en  = 1'b1;
    wr_sel = sel;
    wr_val = val;
    tick();
    wr_en  = 1'b0;
  endtask

  // Wait for busy to fall; returns cycles seen busy and cs_changed pulses
  task automatic wait_idle(output int cycles, output int cs_pulses);
    cycles    = 0;
    cs_pulses = 0;
    while (busy && cycles < 20) begin
      tick();
      cycles++;
      if (cs_changed) cs_pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int pulses;
    int dones;
    logic [15:0] exp_rst [4];
    exp_rst[0] = 16'h0000;
    exp_rst[1] = 16'hFFFF;
    exp_rst[2] = 16'h0000;
    exp_rst[3] = 16'h0000;

    reset = 1'b0; rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_val = '0;
    save_req = 1'b0; restore_req = 1'b0;
    tick(); tick();
    chk("rst_cs", 32'(cs), 32'hFFFF);
    chk("rst_rd", rd_val, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    tick();

    // Reset contents on both ports
    for (int i = 0; i < 4; i++) begin
      rd_sel = {2'(i + 1), 2'(i)};
      tick();
      chk("rst_rd_p0", 32'(rd_val[15:0]), 32'(exp_rst[i]));
      chk("rst_rd_p1", 32'(rd_val[31:16]), 32'(exp_rst[(i + 1) % 4]));
    end

    // Writes and CS change pulse
    write_reg(2'd0, 16'h1234);
    chk("cs_chg_before", 32'(cs_changed), 32'h0);
    write_reg(2'd1, 16'h5678);
    chk("cs_after_wr", 32'(cs), 32'h5678);
    chk("cs_chg_pulse", 32'(cs_changed), 32'h1);
    write_reg(2'd2, 16'h9ABC);
    chk("cs_chg_end", 32'(cs_changed), 32'h0);
    write_reg(2'd3, 16'hDEF0);
    rd_sel = {2'd3, 2'd0};
    tick();
    chk("dual_read", rd_val, 32'hDEF0_1234);

    // Bypass on both ports
    rd_sel = {2'd2, 2'd2};
    write_reg(2'd2, 16'hABCD);
    chk("bypass", rd_val, 32'hABCD_ABCD);
    tick();
    chk("bypass_next", rd_val, 32'hABCD_ABCD);

    // Save, overwrite, restore
    write_reg(2'd0, 16'h1111);
    write_reg(2'd1, 16'h2222);
    write_reg(2'd2, 16'h3333);
    write_reg(2'd3, 16'h4444);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("save_busy", 32'(busy), 32'h1);
    wait_idle(cyc, pulses);
    chk("save_cycles", 32'(cyc), 32'd4);
    chk("save_done", 32'(done), 32'h1);
    tick();
    chk("save_done_end", 32'(done), 32'h0);
    write_reg(2'd0, 16'h0);
    write_reg(2'd1, 16'h0);
    write_reg(2'd2, 16'h0);
    write_reg(2'd3, 16'h0);
    chk("cs_zeroed", 32'(cs), 32'h0);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    pulses = 0;
    wait_idle(cyc, pulses);
    chk("rest_cycles", 32'(cyc), 32'd4);
    chk("rest_done", 32'(done), 32'h1);
    tick();
    if (cs_changed) pulses++;
    chk("rest_cs_pulses", 32'(pulses), 32'd1);
    chk("rest_cs", 32'(cs), 32'h2222);
    rd_sel = {2'd1, 2'd0};
    tick();
    chk("rest_rd01", rd_val, 32'h2222_1111);
    rd_sel = {2'd3, 2'd2};
    tick();
    chk("rest_rd23", rd_val, 32'h4444_3333);

    // Contention: save wins, write and restore dropped while busy
    write_reg(2'd0, 16'h5555);
    save_req = 1'b1; restore_req = 1'b1;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    chk("both_busy", 32'(busy), 32'h1);
    wr_en = 1'b1; wr_sel = 2'd0; wr_val = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    chk("wr_err_pulse", 32'(wr_err), 32'h1);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    chk("wr_err_end", 32'(wr_err), 32'h0);
    wait_idle(cyc, pulses);
    chk("cont_cycles", 32'(cyc - 0), 32'd2);
    chk("cont_done", 32'(done), 32'h1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    chk("no_second_done", 32'(dones), 32'd0);
    chk("cont_idle", 32'(busy), 32'h0);
    rd_sel = {2'd1, 2'd0};
    tick();
    chk("es_unchanged", rd_val, 32'h2222_5555);
    write_reg(2'd0, 16'h0);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_idle(cyc, pulses);
    tick();
    chk("saved_es", 32'(rd_val[15:0]), 32'h5555);

    // Reset mid-restore
    write_reg(2'd1, 16'h7777);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("async_cs", 32'(cs), 32'hFFFF);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_rd", rd_val, 32'h0);
    tick();
    reset = 1'b1;
    rd_sel = {2'd1, 2'd0};
    tick();
    chk("mid_rst_rd", rd_val, 32'hFFFF_0000);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_idle(cyc, pulses);
    chk("zero_rest_cycles", 32'(cyc), 32'd4);
    chk("zero_rest_cs", 32'(cs), 32'h0);
    rd_sel = {2'd3, 2'd1};
    tick();
    chk("zero_rest_rd", rd_val, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
